// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: turns a valid/ready command stream into single
// AXI4-Lite transactions (one outstanding) and returns one response each.
// Optional watchdog compiled in with `define AXI_CMD_MASTER_TIMEOUT_EN.
module axi_lite_cmd_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    // command stream
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    // response stream
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    output logic                              busy,
    // AXI4-Lite master
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);
    localparam int AW       = C_M_AXI_ADDR_WIDTH;
    localparam int DW       = C_M_AXI_DATA_WIDTH;
    localparam int ADDR_LSB = (DW == 64) ? 3 : 2;
    localparam logic [AW-1:0] LSB_MASK = AW'((1 << ADDR_LSB) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP
    } state_t;

    state_t r_state, w_state_nxt;

    logic          r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic          r_aw_done, r_w_done;
    logic [AW-1:0] r_awaddr, r_araddr;
    logic [DW-1:0] r_wdata;
    logic [DW/8-1:0] r_wstrb;
    logic          r_rsp_valid, r_rsp_write, r_rsp_timeout;
    logic [DW-1:0] r_rsp_rdata;
    logic [1:0]    r_rsp_resp;

    logic          w_cmd_hs, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_rsp_hs;
    logic          w_wr_addr_data_fin, w_tmo;
    logic [AW-1:0] w_addr_al;

    assign w_cmd_hs = cmd_valid && (r_state == S_IDLE);
    assign w_aw_hs  = r_awvalid && M_AXI_AWREADY;
    assign w_w_hs   = r_wvalid && M_AXI_WREADY;
    assign w_b_hs   = r_bready && M_AXI_BVALID;
    assign w_ar_hs  = r_arvalid && M_AXI_ARREADY;
    assign w_r_hs   = r_rready && M_AXI_RVALID;
    assign w_rsp_hs = r_rsp_valid && rsp_ready;
    // both channels finished, counting a handshake landing this very cycle
    assign w_wr_addr_data_fin = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
    assign w_addr_al = cmd_addr & ~LSB_MASK;

`ifdef AXI_CMD_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_wd_cnt;

    // watchdog: restart per command, count while waiting on the slave, saturate
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET)
            r_wd_cnt <= '0;
        else if (w_cmd_hs)
            r_wd_cnt <= '0;
        else if (r_state != S_IDLE && r_state != S_RSP && r_wd_cnt != CW'(TIMEOUT_CYCLES))
            r_wd_cnt <= r_wd_cnt + 1'b1;
    end
    assign w_tmo = (r_wd_cnt == CW'(TIMEOUT_CYCLES));
`else
    assign w_tmo = 1'b0;
`endif

    // state register
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) r_state <= S_IDLE;
        else              r_state <= w_state_nxt;
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:         if (w_cmd_hs) w_state_nxt = cmd_write ? S_WR_ADDR_DATA : S_RD_ADDR;
            S_WR_ADDR_DATA: if (w_wr_addr_data_fin) w_state_nxt = S_WR_RESP;
            S_WR_RESP:      if (w_b_hs) w_state_nxt = S_RSP;
            S_RD_ADDR:      if (w_ar_hs) w_state_nxt = S_RD_DATA;
            S_RD_DATA:      if (w_r_hs) w_state_nxt = S_RSP;
            S_RSP:          if (w_rsp_hs) w_state_nxt = S_IDLE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // registered AXI channel controls and response fields
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_awvalid <= 1'b0; r_wvalid <= 1'b0; r_bready <= 1'b0;
            r_arvalid <= 1'b0; r_rready <= 1'b0;
            r_aw_done <= 1'b0; r_w_done <= 1'b0;
            r_awaddr  <= '0;   r_araddr <= '0;
            r_wdata   <= '0;   r_wstrb  <= '0;
            r_rsp_valid <= 1'b0; r_rsp_write <= 1'b0; r_rsp_timeout <= 1'b0;
            r_rsp_rdata <= '0;   r_rsp_resp  <= 2'b00;
        end else begin
            if (w_cmd_hs) begin
                r_rsp_write <= cmd_write;
                if (cmd_write) begin
                    r_awaddr  <= w_addr_al;
                    r_wdata   <= cmd_wdata;
                    r_wstrb   <= cmd_wstrb;
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end else begin
                    r_araddr  <= w_addr_al;
                    r_arvalid <= 1'b1;
                end
            end
            if (w_aw_hs) begin r_awvalid <= 1'b0; r_aw_done <= 1'b1; end
            if (w_w_hs)  begin r_wvalid  <= 1'b0; r_w_done  <= 1'b1; end
            if (r_state == S_WR_ADDR_DATA && w_wr_addr_data_fin) r_bready <= 1'b1;
            if (w_b_hs) begin
                r_bready      <= 1'b0;
                r_rsp_valid   <= 1'b1;
                r_rsp_resp    <= M_AXI_BRESP;
                r_rsp_rdata   <= '0;
                r_rsp_timeout <= w_tmo;
            end
            if (w_ar_hs) begin r_arvalid <= 1'b0; r_rready <= 1'b1; end
            if (w_r_hs) begin
                r_rready      <= 1'b0;
                r_rsp_valid   <= 1'b1;
                r_rsp_resp    <= M_AXI_RRESP;
                r_rsp_rdata   <= M_AXI_RDATA;
                r_rsp_timeout <= w_tmo;
            end
            if (w_rsp_hs) r_rsp_valid <= 1'b0;
        end
    end

    assign cmd_ready     = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign rsp_valid     = r_rsp_valid;
    assign rsp_write     = r_rsp_write;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_timeout   = r_rsp_timeout;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with a small register-file slave
// whose per-channel ready/response delays are adjustable.
module tb_axi_lite_cmd_master;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [5:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;

    axi_lite_cmd_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(6), .TIMEOUT_CYCLES(16)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(s_awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(s_wready),
        .M_AXI_BRESP(s_bresp), .M_AXI_BVALID(s_bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(s_arready),
        .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RVALID(s_rvalid), .M_AXI_RREADY(rready)
    );

    // ---------------- slave model ----------------
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] bresp_v = 2'b00, rresp_v = 2'b00;
    int aw_c, w_c, b_c, ar_c, r_c;
    logic got_aw, got_w, got_ar;
    logic [5:0] wa, ra;
    logic [31:0] wd;
    logic [3:0] ws;
    logic [31:0] mem [16];
    logic [3:0] ridx;

    assign ridx = got_ar ? ra[5:2] : araddr[5:2];

    always @(posedge clk) begin
        if (rst) begin
            s_awready <= 0; s_wready <= 0; s_bvalid <= 0; s_arready <= 0; s_rvalid <= 0;
            s_bresp <= 0; s_rresp <= 0; s_rdata <= 0;
            aw_c <= 0; w_c <= 0; b_c <= 0; ar_c <= 0; r_c <= 0;
            got_aw <= 0; got_w <= 0; got_ar <= 0; wa <= 0; ra <= 0; wd <= 0; ws <= 0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else begin
            if (s_awready) begin s_awready <= 0; got_aw <= 1; wa <= awaddr; end
            else if (awvalid && !got_aw) begin if (aw_c >= aw_dly) s_awready <= 1; aw_c <= aw_c + 1; end
            if (s_wready) begin s_wready <= 0; got_w <= 1; wd <= wdata; ws <= wstrb; end
            else if (wvalid && !got_w) begin if (w_c >= w_dly) s_wready <= 1; w_c <= w_c + 1; end
            if (s_bvalid) begin
                if (bready) begin
                    s_bvalid <= 0; got_aw <= 0; got_w <= 0; aw_c <= 0; w_c <= 0; b_c <= 0;
                    for (int i = 0; i < 4; i++)
                        if (ws[i]) mem[wa[5:2]][8*i +: 8] <= wd[8*i +: 8];
                end
            end else if ((got_aw || s_awready) && (got_w || s_wready)) begin
                if (b_c >= b_dly) begin s_bvalid <= 1; s_bresp <= bresp_v; end
                b_c <= b_c + 1;
            end
            if (s_arready) begin s_arready <= 0; got_ar <= 1; ra <= araddr; end
            else if (arvalid && !got_ar) begin if (ar_c >= ar_dly) s_arready <= 1; ar_c <= ar_c + 1; end
            if (s_rvalid) begin
                if (rready) begin s_rvalid <= 0; got_ar <= 0; ar_c <= 0; r_c <= 0; end
            end else if (got_ar || s_arready) begin
                if (r_c >= r_dly) begin s_rvalid <= 1; s_rdata <= mem[ridx]; s_rresp <= rresp_v; end
                r_c <= r_c + 1;
            end
        end
    end

    // ---------------- monitors ----------------
    int rsp_cnt = 0, aw_only_cnt = 0, proto_err = 0;
    logic [5:0] last_araddr = 6'h3F;
    logic pend_aw = 0, pend_w = 0, pend_ar = 0;
    logic [5:0] awq, arq;
    logic [31:0] wq;

    // count handshakes and remember which valids must still be held
    always @(posedge clk) begin
        if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
        if (arvalid && s_arready) last_araddr <= araddr;
        pend_aw <= awvalid && !s_awready && !rst; awq <= awaddr;
        pend_w  <= wvalid && !s_wready && !rst;   wq  <= wdata;
        pend_ar <= arvalid && !s_arready && !rst; arq <= araddr;
    end

    // valid must hold with stable payload until its handshake
    always @(negedge clk) begin
        if ((pend_aw && (!awvalid || awaddr != awq)) || (pend_w && (!wvalid || wdata != wq)) ||
            (pend_ar && (!arvalid || araddr != arq)))
            proto_err <= proto_err + 1;
        if (awvalid && !wvalid) aw_only_cnt <= aw_only_cnt + 1;
    end

    // ---------------- checking ----------------
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // issue one command, collect its response; hold = cycles rsp_ready stays low
    task automatic run_cmd(input logic w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int hold, output logic [31:0] rd, output logic [1:0] rs,
                           output logic tmo, output logic wr, output int lat,
                           output logic rdy_after, output logic stable);
        int n;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        rsp_ready = (hold == 0);
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("cmd_accept_timeout", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 200);
        if (!rsp_valid) chk("rsp_timeout_wait", rsp_valid, 1);
        rd = rsp_rdata; rs = rsp_resp; tmo = rsp_timeout; wr = rsp_write;
        stable = 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            stable &= rsp_valid && rsp_rdata == rd && rsp_resp == rs && rsp_write == wr && !cmd_ready;
        end
        if (hold > 0) begin @(posedge clk); #1 rsp_ready = 1; end
        @(posedge clk);
        @(negedge clk);
        rdy_after = cmd_ready;
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    logic        tmo, wr, rdy, stb;
    int          lat, c0, r0, n;

    initial begin
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, 36'h0);
        chk("rst_addr_data", {awaddr, araddr, wdata, wstrb}, 48'h0);

        // basic write then readback, with cycle timing
        run_cmd(1, 6'h08, 32'hDEADBEEF, 4'hF, 0, rd, rs, tmo, wr, lat, rdy, stb);
        chk("wr_write", wr, 1); chk("wr_resp", rs, 0); chk("wr_rdata", rd, 0);
        chk("wr_lat", lat, 4); chk("wr_next_ready", rdy, 1); chk("wr_tmo", tmo, 0);
        run_cmd(0, 6'h08, 32'h0, 4'h0, 0, rd, rs, tmo, wr, lat, rdy, stb);
        chk("rd_data", rd, 32'hDEADBEEF); chk("rd_write", wr, 0);
        chk("rd_resp", rs, 0); chk("rd_lat", lat, 4); chk("rd_next_ready", rdy, 1);

        // partial strobe merge
        run_cmd(1, 6'h0C, 32'h11223344, 4'hF, 0, rd, rs, tmo, wr, lat, rdy, stb);
        run_cmd(1, 6'h0C, 32'h0000AA00, 4'h2, 0, rd, rs, tmo, wr, lat, rdy, stb);
        run_cmd(0, 6'h0C, 32'h0, 4'h0, 0, rd, rs, tmo, wr, lat, rdy, stb);
        chk("strb_merge", rd, 32'h1122AA44);

        // AWREADY lags WREADY by 3 cycles
        aw_dly = 3; c0 = aw_only_cnt; r0 = rsp_cnt;
        run_cmd(1, 6'h10, 32'hCAFEF00D, 4'hF, 0, rd, rs, tmo, wr, lat, rdy, stb);
        repeat (10) @(negedge clk);
        chk("aw_hold_after_w", (aw_only_cnt - c0) > 0, 1);
        chk("aw_delay_one_rsp", rsp_cnt - r0, 1);
        chk("aw_delay_lat", lat, 7);
        aw_dly = 0;
        run_cmd(0, 6'h10, 32'h0, 4'h0, 0, rd, rs, tmo, wr, lat, rdy, stb);
        chk("aw_delay_readback", rd, 32'hCAFEF00D);

        // unaligned read address
        run_cmd(0, 6'h0B, 32'h0, 4'h0, 0, rd, rs, tmo, wr, lat, rdy, stb);
        chk("unaligned_araddr", last_araddr, 6'h08);
        chk("unaligned_rdata", rd, 32'hDEADBEEF);

        // SLVERR read, response held under backpressure
        rresp_v = 2'b10;
        run_cmd(0, 6'h04, 32'h0, 4'h0, 5, rd, rs, tmo, wr, lat, rdy, stb);
        chk("slverr_resp", rs, 2'b10);
        chk("slverr_rdata", rd, 32'h0);
        chk("hold_stable", stb, 1);
        chk("hold_next_ready", rdy, 1);
        rresp_v = 2'b00;

        // late B response, watchdog outcome depends on build
        b_dly = 20; bresp_v = 2'b10;
        run_cmd(1, 6'h14, 32'h55AA55AA, 4'hF, 0, rd, rs, tmo, wr, lat, rdy, stb);
        chk("late_b_resp", rs, 2'b10);
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
        chk("late_b_timeout", tmo, 1);
`else
        chk("late_b_timeout", tmo, 0);
`endif
        b_dly = 0; bresp_v = 2'b00;

        // reset while waiting in WR_RESP
        b_dly = 10;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 6'h18; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
        rsp_ready = 1;
        @(posedge clk); #1 cmd_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bready && n < 50);
        chk("mid_rst_reached_wr_resp", bready, 1);
        r0 = rsp_cnt;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
        repeat (15) @(negedge clk);
        chk("mid_rst_no_rsp", rsp_cnt - r0, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        b_dly = 0;

        chk("protocol_hold", proto_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
